// File: rtl/nibble_serial_adder_ctrl.sv
// nibble_serial_adder_ctrl
// Adds two WIDTH-bit operands by reusing one 4-bit ripple-carry slice,
// one nibble per clock, starting with the least significant nibble. The carry
// between nibbles is held in a register, so no carry path spans more than
// four bits.
//
// Ports:
//   clk   - rising-edge clock
//   rst   - synchronous active-high reset
//   start - request, sampled only while idle
//   A, B  - WIDTH-bit operands, captured on the accepting edge
//   Cin   - carry-in, captured on the accepting edge
//   busy  - high while an operation is running or being reported
//   done  - one-cycle pulse when Sum/Cout hold a new result
//   Sum   - registered result, held until the next result loads
//   Cout  - registered carry-out of the top nibble

module ripple_adder_4bit (
    input  logic [3:0] a,
    input  logic [3:0] b,
    input  logic       ci,
    output logic [3:0] s,
    output logic       co
);
    logic [4:0] c;

    assign c[0] = ci;

    for (genvar i = 0; i < 4; i++) begin : g_fa
        assign s[i]   = a[i] ^ b[i] ^ c[i];
        assign c[i+1] = (a[i] & b[i]) | (c[i] & (a[i] ^ b[i]));
    end

    assign co = c[4];
endmodule

module nibble_serial_adder_ctrl #(
    parameter int WIDTH = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [WIDTH-1:0] A,
    input  logic [WIDTH-1:0] B,
    input  logic             Cin,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] Sum,
    output logic             Cout
);
    localparam int N  = WIDTH / 4;
    localparam int CW = (N > 1) ? $clog2(N) : 1;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t           state_q, state_d;
    logic [WIDTH-1:0] a_sh_q, a_sh_d;
    logic [WIDTH-1:0] b_sh_q, b_sh_d;
    logic [WIDTH-1:0] s_sh_q, s_sh_d;
    logic             cy_q, cy_d;
    logic [CW-1:0]    cnt_q, cnt_d;
    logic [WIDTH-1:0] sum_q, sum_d;
    logic             cout_q, cout_d;

    logic [3:0]       slice_s;
    logic             slice_cout;
    logic [WIDTH-1:0] s_shift_in;

    ripple_adder_4bit u_slice (
        .a  (a_sh_q[3:0]),
        .b  (b_sh_q[3:0]),
        .ci (cy_q),
        .s  (slice_s),
        .co (slice_cout)
    );

    // The newest nibble enters at the top; after N steps the first nibble
    // has travelled down to bit 0. A single-nibble build has nothing to shift.
    if (WIDTH > 4) begin : g_wide
        assign s_shift_in = {slice_s, s_sh_q[WIDTH-1:4]};
    end else begin : g_narrow
        assign s_shift_in = slice_s;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            a_sh_q  <= '0;
            b_sh_q  <= '0;
            s_sh_q  <= '0;
            cy_q    <= 1'b0;
            cnt_q   <= '0;
            sum_q   <= '0;
            cout_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            a_sh_q  <= a_sh_d;
            b_sh_q  <= b_sh_d;
            s_sh_q  <= s_sh_d;
            cy_q    <= cy_d;
            cnt_q   <= cnt_d;
            sum_q   <= sum_d;
            cout_q  <= cout_d;
        end
    end

    // Sum/Cout load only on the final step, so partial nibbles never reach
    // the outputs.
    always_comb begin
        state_d = state_q;
        a_sh_d  = a_sh_q;
        b_sh_d  = b_sh_q;
        s_sh_d  = s_sh_q;
        cy_d    = cy_q;
        cnt_d   = cnt_q;
        sum_d   = sum_q;
        cout_d  = cout_q;

        case (state_q)
            IDLE: begin
                if (start) begin
                    a_sh_d  = A;
                    b_sh_d  = B;
                    cy_d    = Cin;
                    cnt_d   = '0;
                    state_d = RUN;
                end
            end
            RUN: begin
                a_sh_d = a_sh_q >> 4;
                b_sh_d = b_sh_q >> 4;
                s_sh_d = s_shift_in;
                cy_d   = slice_cout;
                cnt_d  = cnt_q + 1'b1;
                if (cnt_q == CW'(N - 1)) begin
                    sum_d   = s_shift_in;
                    cout_d  = slice_cout;
                    state_d = DONE;
                end
            end
            DONE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    assign busy = (state_q == RUN) || (state_q == DONE);
    assign done = (state_q == DONE);
    assign Sum  = sum_q;
    assign Cout = cout_q;
endmodule

// File: tb/tb_nibble_serial_adder_ctrl.sv
// tb_nibble_serial_adder_ctrl
// Directed bench for nibble_serial_adder_ctrl. A 16-bit instance covers the
// main arithmetic, latency, start-while-busy and reset-abort cases; a 4-bit
// instance covers the single-step build. Expected values are hand-computed.

module tb_nibble_serial_adder_ctrl;
    logic        clk = 1'b0;
    logic        rst;

    logic        start;
    logic [15:0] a_in;
    logic [15:0] b_in;
    logic        cin;
    logic        busy;
    logic        done;
    logic [15:0] sum;
    logic        cout;

    logic        start4;
    logic [3:0]  a4;
    logic [3:0]  b4;
    logic        cin4;
    logic        busy4;
    logic        done4;
    logic [3:0]  sum4;
    logic        cout4;

    int pass_count  = 0;
    int check_count = 0;

    always #5 clk = ~clk;

    nibble_serial_adder_ctrl #(.WIDTH(16)) dut (
        .clk   (clk),
        .rst   (rst),
        .start (start),
        .A     (a_in),
        .B     (b_in),
        .Cin   (cin),
        .busy  (busy),
        .done  (done),
        .Sum   (sum),
        .Cout  (cout)
    );

    nibble_serial_adder_ctrl #(.WIDTH(4)) dut4 (
        .clk   (clk),
        .rst   (rst),
        .start (start4),
        .A     (a4),
        .B     (b4),
        .Cin   (cin4),
        .busy  (busy4),
        .done  (done4),
        .Sum   (sum4),
        .Cout  (cout4)
    );

    // Advance past one rising edge and settle, so outputs are sampled away
    // from the edge.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic applyStimulus(input logic s, input logic [15:0] a,
                                 input logic [15:0] b, input logic c);
        start = s;
        a_in  = a;
        b_in  = b;
        cin   = c;
    endtask

    task automatic checkOutput(input string tag, input logic [31:0] observed,
                               input logic [31:0] expected);
        check_count++;
        assert (observed === expected) pass_count++;
        else $error("[TB] FAIL %s observed=%0h expected=%0h", tag, observed, expected);
    endtask

    // Starts one 16-bit addition, scrambles the inputs after capture, waits
    // (bounded) for done and checks latency, result, and return to idle.
    task automatic runOp16(input logic [15:0] a, input logic [15:0] b,
                           input logic c, input logic [15:0] exp_sum,
                           input logic exp_cout, input string tag);
        int edges;
        logic seen;
        applyStimulus(1'b1, a, b, c);
        tick();
        applyStimulus(1'b0, ~a, ~b, ~c);
        edges = 0;
        seen  = 1'b0;
        while (!seen && edges < 20) begin
            tick();
            edges++;
            if (done) seen = 1'b1;
        end
        checkOutput({tag, "_done_seen"}, 32'(seen), 32'd1);
        checkOutput({tag, "_latency"}, 32'(edges), 32'd4);
        checkOutput({tag, "_sum"}, 32'(sum), 32'(exp_sum));
        checkOutput({tag, "_cout"}, 32'(cout), 32'(exp_cout));
        tick();
        checkOutput({tag, "_idle_busy"}, 32'(busy), 32'd0);
        checkOutput({tag, "_idle_done"}, 32'(done), 32'd0);
    endtask

    initial begin
        int done_count;

        rst    = 1'b1;
        start4 = 1'b0;
        a4     = 4'h0;
        b4     = 4'h0;
        cin4   = 1'b0;
        applyStimulus(1'b0, 16'h0000, 16'h0000, 1'b0);
        tick();
        tick();
        checkOutput("reset_busy", 32'(busy), 32'd0);
        checkOutput("reset_done", 32'(done), 32'd0);
        checkOutput("reset_sum", 32'(sum), 32'd0);
        checkOutput("reset_cout", 32'(cout), 32'd0);
        rst = 1'b0;

        // Zero operands with cycle-by-cycle busy/done tracking.
        applyStimulus(1'b1, 16'h0000, 16'h0000, 1'b0);
        tick();
        applyStimulus(1'b0, 16'h0000, 16'h0000, 1'b0);
        for (int i = 0; i < 4; i++) begin
            checkOutput($sformatf("zero_run%0d_busy", i), 32'(busy), 32'd1);
            checkOutput($sformatf("zero_run%0d_done", i), 32'(done), 32'd0);
            tick();
        end
        checkOutput("zero_done", 32'(done), 32'd1);
        checkOutput("zero_done_busy", 32'(busy), 32'd1);
        checkOutput("zero_sum", 32'(sum), 32'h0000);
        checkOutput("zero_cout", 32'(cout), 32'd0);
        tick();
        checkOutput("zero_idle_busy", 32'(busy), 32'd0);
        checkOutput("zero_idle_done", 32'(done), 32'd0);

        runOp16(16'hFFFF, 16'h0001, 1'b0, 16'h0000, 1'b1, "ripple");
        runOp16(16'h1234, 16'h4321, 1'b1, 16'h5556, 1'b0, "mixed");
        runOp16(16'hFFFF, 16'hFFFF, 1'b1, 16'hFFFF, 1'b1, "allones");
        runOp16(16'h8000, 16'h8000, 1'b0, 16'h0000, 1'b1, "msb");
        runOp16(16'h0F0F, 16'h00F1, 1'b0, 16'h1000, 1'b0, "midcarry");

        // Start requests while busy, including the done cycle, are ignored.
        done_count = 0;
        applyStimulus(1'b1, 16'h0002, 16'h0002, 1'b0);
        tick();
        applyStimulus(1'b0, 16'h0002, 16'h0002, 1'b0);
        for (int e = 1; e <= 4; e++) begin
            if (e == 2 || e == 4) applyStimulus(1'b1, 16'h00FF, 16'h00FF, 1'b0);
            else applyStimulus(1'b0, 16'h00FF, 16'h00FF, 1'b0);
            tick();
            if (done) done_count++;
        end
        checkOutput("busy_start_done", 32'(done), 32'd1);
        checkOutput("busy_start_sum", 32'(sum), 32'h0004);
        applyStimulus(1'b1, 16'h00FF, 16'h00FF, 1'b0);
        tick();
        if (done) done_count++;
        applyStimulus(1'b0, 16'h0000, 16'h0000, 1'b0);
        checkOutput("busy_start_idle", 32'(busy), 32'd0);
        tick();
        if (done) done_count++;
        checkOutput("busy_start_not_captured", 32'(busy), 32'd0);
        checkOutput("busy_start_done_count", 32'(done_count), 32'd1);
        checkOutput("busy_start_sum_hold", 32'(sum), 32'h0004);
        runOp16(16'h00FF, 16'h00FF, 1'b0, 16'h01FE, 1'b0, "after_busy");

        // Reset in the middle of a run aborts it without a done pulse.
        applyStimulus(1'b1, 16'h1111, 16'h2222, 1'b0);
        tick();
        applyStimulus(1'b0, 16'h1111, 16'h2222, 1'b0);
        tick();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        checkOutput("abort_busy", 32'(busy), 32'd0);
        checkOutput("abort_sum", 32'(sum), 32'd0);
        checkOutput("abort_cout", 32'(cout), 32'd0);
        done_count = 0;
        for (int i = 0; i < 6; i++) begin
            tick();
            if (done) done_count++;
        end
        checkOutput("abort_no_done", 32'(done_count), 32'd0);
        runOp16(16'h1111, 16'h2222, 1'b0, 16'h3333, 1'b0, "after_abort");

        // Reset and start on the same edge: reset wins.
        rst = 1'b1;
        applyStimulus(1'b1, 16'h0001, 16'h0001, 1'b0);
        tick();
        rst = 1'b0;
        applyStimulus(1'b0, 16'h0000, 16'h0000, 1'b0);
        checkOutput("rst_start_busy", 32'(busy), 32'd0);

        // Single-nibble build: one RUN edge, done after the next edge.
        start4 = 1'b1; a4 = 4'h6; b4 = 4'hA; cin4 = 1'b0;
        tick();
        start4 = 1'b0; a4 = 4'h0; b4 = 4'h0;
        checkOutput("w4_a_busy", 32'(busy4), 32'd1);
        checkOutput("w4_a_run_done", 32'(done4), 32'd0);
        tick();
        checkOutput("w4_a_done", 32'(done4), 32'd1);
        checkOutput("w4_a_sum", 32'(sum4), 32'h0);
        checkOutput("w4_a_cout", 32'(cout4), 32'd1);
        tick();
        checkOutput("w4_a_idle", 32'(busy4), 32'd0);
        start4 = 1'b1; a4 = 4'h2; b4 = 4'h4; cin4 = 1'b0;
        tick();
        start4 = 1'b0; a4 = 4'hF; b4 = 4'hF; cin4 = 1'b1;
        tick();
        checkOutput("w4_b_done", 32'(done4), 32'd1);
        checkOutput("w4_b_sum", 32'(sum4), 32'h6);
        checkOutput("w4_b_cout", 32'(cout4), 32'd0);

        $display("%0d/%0d checks passed", pass_count, check_count);
        $finish;
    end
endmodule
